// File: rtl/axi_burst_master.sv
// AXI4 burst master: executes one read or write burst per accepted command,
// captures read beats in a local buffer and reports a worst-case response on done.
module axi_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_burst,
  input  logic [DATA_W-1:0] cmd_wbase,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              len_err,
  output logic              cmd_err,
  input  logic [LEN_W-1:0]  rbuf_idx,
  output logic [DATA_W-1:0] rbuf_data,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int        BYTE_SHIFT = $clog2(STRB_W);
  localparam logic [2:0] AX_SIZE   = 3'(BYTE_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [DATA_W-1:0]   wbase_q, wbase_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [1:0]          resp_q, resp_d;
  logic                len_err_q, len_err_d;
  logic                cmd_err_q, cmd_err_d;
  logic [13:0]         span_s;
  logic                cross_4k_s;
  logic                last_beat_s;
  logic [DATA_W-1:0]   rbuf_q [2**LEN_W];

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // End offset of an INCR burst within its 4 KB page; anything above 4096 crosses the page.
  assign span_s      = {2'b00, addr_q[11:0]} + ((14'(len_q) + 14'd1) << BYTE_SHIFT);
  assign cross_4k_s  = (burst_q == 2'b01) && (span_s > 14'd4096);
  assign last_beat_s = (beat_q == len_q);

  // Next-state and datapath update logic
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    wbase_d   = wbase_q;
    beat_d    = beat_q;
    resp_d    = resp_q;
    len_err_d = len_err_q;
    cmd_err_d = cmd_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d   = cmd_write;
          addr_d    = cmd_addr;
          len_d     = cmd_len;
          burst_d   = cmd_burst;
          wbase_d   = cmd_wbase;
          beat_d    = '0;
          resp_d    = 2'b00;
          len_err_d = 1'b0;
          cmd_err_d = 1'b0;
          state_d   = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (burst_q[1] || cross_4k_s) begin
          cmd_err_d = 1'b1;
          resp_d    = 2'b10;
          state_d   = S_DONE;
        end else if (write_q) begin
          state_d = S_WADDR;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RADDR: begin
        if (arready) begin
          state_d = S_RDATA;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RDATA: begin
        if (rvalid) begin
          beat_d = beat_q + LEN_W'(1);
          resp_d = resp_max(resp_q, rresp);
          if (rlast || last_beat_s) begin
            len_err_d = rlast ^ last_beat_s;
            state_d   = S_DONE;
          end else begin
            state_d = S_RDATA;
          end
        end else begin
          state_d = S_RDATA;
        end
      end
      S_WADDR: begin
        if (awready) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_WADDR;
        end
      end
      S_WDATA: begin
        if (wready && last_beat_s) begin
          state_d = S_WRESP;
        end else if (wready) begin
          beat_d = beat_q + LEN_W'(1);
        end else begin
          state_d = S_WDATA;
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          resp_d  = resp_max(resp_q, bresp);
          state_d = S_DONE;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and command registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= 2'b00;
      wbase_q   <= '0;
      beat_q    <= '0;
      resp_q    <= 2'b00;
      len_err_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      wbase_q   <= wbase_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      len_err_q <= len_err_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Read-beat buffer; intentionally not reset so stale entries survive
  always_ff @(posedge aclk) begin
    if ((state_q == S_RDATA) && rvalid) begin
      rbuf_q[beat_q] <= rdata;
    end
  end

  assign rbuf_data = rbuf_q[rbuf_idx];
  assign cmd_ready = (state_q == S_IDLE);

  assign arvalid = (state_q == S_RADDR);
  assign araddr  = arvalid ? addr_q : '0;
  assign arlen   = 8'(len_q);
  assign arsize  = AX_SIZE;
  assign arburst = burst_q;
  assign rready  = (state_q == S_RDATA);

  assign awvalid = (state_q == S_WADDR);
  assign awaddr  = awvalid ? addr_q : '0;
  assign awlen   = 8'(len_q);
  assign awsize  = AX_SIZE;
  assign awburst = burst_q;

  assign wvalid = (state_q == S_WDATA);
  assign wdata  = wvalid ? (wbase_q + DATA_W'(beat_q)) : '0;
  assign wstrb  = '1;
  assign wlast  = wvalid && last_beat_s;
  assign bready = (state_q == S_WRESP);

  assign done      = (state_q == S_DONE);
  assign done_resp = done ? resp_q : 2'b00;
  assign len_err   = done && len_err_q;
  assign cmd_err   = done && cmd_err_q;

endmodule
